// File: rtl/position_accumulator_if.sv
// Bus bundle for the position accumulator: preset, delta handshake and position/status outputs.
interface position_accumulator_if #(
  parameter int WIDTH = 64
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             DV_in;
  logic [WIDTH-1:0] in_delta;
  logic             ready;
  logic             DV_out;
  logic [WIDTH-1:0] Position;
  logic             OVF;
  logic             MSB;

  modport master (
    output load, load_val, DV_in, in_delta,
    input  ready, DV_out, Position, OVF, MSB
  );

  modport slave (
    input  load, load_val, DV_in, in_delta,
    output ready, DV_out, Position, OVF, MSB
  );
endinterface

// File: rtl/position_accumulator.sv
// Integrates signed deltas into an absolute position using a CHUNK-bit-per-cycle adder.
//   state | meaning
//   IDLE  | ready; accepts load (priority) or a delta
//   ADD   | one chunk added per cycle, full result committed on the last chunk
//   DONE  | DV_out pulse for the freshly committed Position
module position_accumulator #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic clk,
  input logic rst,
  position_accumulator_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pos_q, pos_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   delta_q, delta_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [CHUNK:0]     sum;
  logic               last_chunk;

  assign sum = {1'b0, work_q[idx_q*CHUNK +: CHUNK]}
             + {1'b0, delta_q[idx_q*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      work_q  <= '0;
      delta_q <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      work_q  <= work_d;
      delta_q <= delta_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    work_d  = work_q;
    delta_d = delta_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          pos_d = bus.load_val;
          ovf_d = 1'b0;
        end else if (bus.DV_in) begin
          delta_d = bus.in_delta;
          work_d  = pos_q;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          // Position stays untouched until now, so its sign is the pre-add sign.
          pos_d = work_d;
          if ((pos_q[WIDTH-1] == delta_q[WIDTH-1]) && (sum[CHUNK-1] != pos_q[WIDTH-1]))
            ovf_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.DV_out   = (state_q == DONE);
  assign bus.Position = pos_q;
  assign bus.OVF      = ovf_q;
  assign bus.MSB      = pos_q[WIDTH-1];
endmodule
